// File: rtl/bcd_scan_driver.sv
// Four-digit seven-segment scan controller fed from the display device register.
// The BCD word is shadowed once per frame so a display frame never shows a
// mix of old and new digits. Digit 3 shows a frame heartbeat on its decimal point.
module bcd_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_word,
    input  logic        disp_en,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("bcd_scan_driver: SCAN_DIV must be at least 2");
    end
    if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank_cyc
        $error("bcd_scan_driver: BLANK_CYC must be below SCAN_DIV");
    end

    // Segment pattern {g,f,e,d,c,b,a}, active-low, for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    // Leading-zero suppression: digit 2 hides a zero, digit 1 hides a zero only
    // when everything above it is zero too. Digits 0 and 3 are never hidden.
    function automatic logic digit_blank(input logic [1:0]  sel,
                                         input logic [11:0] val,
                                         input logic        lz);
        logic hide;
        hide = 1'b0;
        if (lz) begin
            case (sel)
                2'd2:    hide = (val[11:8] == 4'h0);
                2'd1:    hide = (val[11:4] == 8'h00);
                default: hide = 1'b0;
            endcase
        end
        return hide;
    endfunction

    // Nibble of the shadowed word belonging to the active digit slot.
    function automatic logic [3:0] pick_nibble(input logic [1:0]  sel,
                                               input logic [11:0] val);
        logic [3:0] nib;
        case (sel)
            2'd0:    nib = val[3:0];
            2'd1:    nib = val[7:4];
            2'd2:    nib = val[11:8];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       dsel;
    logic [11:0]      shadow;
    logic             hb;

    logic             cnt_last;
    logic             frame_end;
    logic             in_guard;
    logic             blank_p0;
    logic [3:0]       nib_p0;
    logic [3:0]       an_p0;
    logic [7:0]       seg_p0;

    assign cnt_last  = (div_cnt == CNT_LAST);
    assign frame_end = cnt_last && (dsel == 2'd3);
    assign in_guard  = (div_cnt < BLANK_END);
    assign blank_p0  = digit_blank(dsel, shadow, lz_blank);
    assign nib_p0    = pick_nibble(dsel, shadow);

    // Slot timer, digit select, per-frame shadow capture and heartbeat toggle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt    <= '0;
            dsel       <= 2'd0;
            shadow     <= 12'h000;
            hb         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (cnt_last) begin
                div_cnt <= '0;
                dsel    <= dsel + 2'd1;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
            if (frame_end) begin
                shadow <= bcd_word;
                hb     <= ~hb;
            end
        end
    end

    // ---- stage 0: decode current slot into anode/segment patterns ----
    // Priority: dark/guard band, then suppressed digit, then the digit glyph.
    always_comb begin
        an_p0  = 4'hF;
        seg_p0 = 8'hFF;
        if (disp_en && !in_guard) begin
            an_p0 = ~(4'b0001 << dsel);
            if (!blank_p0) begin
                if (dsel == 2'd3) begin
                    seg_p0 = {~hb, 7'h7F};
                end else begin
                    seg_p0 = {1'b1, hex7(nib_p0)};
                end
            end
        end
    end

    // ---- stage 1: registered pin drivers ----
    // Pins follow the decode one cycle later; reset forces everything dark.
    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= 4'hF;
            seg <= 8'hFF;
        end else begin
            an  <= an_p0;
            seg <= seg_p0;
        end
    end

endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Hardware scan controller for the 4-digit seven-segment display. It sits directly downstream of the data memory's display device register (word 0x40000010).
- Consumes the 12-bit BCD word as three hex nibbles and time-multiplexes them onto the anode and segment pins.
- Digit 3 carries a frame heartbeat on its decimal point.
- Input is shadowed once per frame, so software writes never tear a displayed frame.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (legal: >=2).
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off for anti-ghosting (legal: < SCAN_DIV).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- bcd_word  in  12  display value from the memory device register; [3:0] digit0, [7:4] digit1, [11:8] digit2.
- disp_en  in  1  1 = display on; 0 = force all dark (counters keep running).
- lz_blank  in  1  1 = suppress leading zeros on digits 2 and 1.
- an  out  4  anode enables, active-low, an[i] = digit i.
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- frame_tick  out  1  one-cycle pulse marking a shadow capture.

Behaviour:
- Reset (rst==0 at an edge) sets the following, overriding all other activity including mid-frame:
  - div_cnt=0, dsel=0, shadow=12'h000, hb=0.
  - an=4'hF, seg=8'hFF, frame_tick=0.
- div_cnt counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and dsel advances 0->1->2->3->0.
- Shadow capture happens on the edge where div_cnt==SCAN_DIV-1 and dsel==3. On that edge:
  - shadow<=bcd_word.
  - hb<=~hb.
  - frame_tick<=1 for exactly the next cycle; frame_tick is 0 otherwise.
- bcd_word changes at any other time have no effect until the next capture.
- an and seg are registers with 1-cycle latency. Each edge loads decode(dsel, div_cnt, shadow, hb, disp_en, lz_blank) as sampled before that edge.
- Decode priority:
  1. disp_en==0 or div_cnt<BLANK_CYC -> an=4'hF, seg=8'hFF.
  2. Digit blanked -> an drives digit dsel low, seg=8'hFF.
  3. Otherwise -> an has bit dsel low and all other bits high. Digit 0..2: seg={1'b1, hex7(nibble)}. Digit 3: seg={~hb, 7'h7F}.
- Leading-zero suppression (lz_blank==1 only):
  - digit2 blank if shadow[11:8]==0.
  - digit1 blank if shadow[11:4]==0.
  - digit0 is never blanked.
- hex7 uses {g..a} active-low, listed for nibble 0..F:
  - 0..7: 40,79,24,30,19,12,02,78.
  - 8..F: 00,10,08,03,46,21,06,0E.
- Full-byte seg examples: 0->C0, 1->F9, 3->B0, 5->92, 9->90.
- disp_en and lz_blank are sampled every cycle, not shadowed; a change takes effect at the next edge.
- There is no handshake. The block reads bcd_word continuously and never stalls the pipeline.

Test Plan:
All tests use SCAN_DIV=8, BLANK_CYC=2 unless noted.
- Reset release: hold rst=0 for 3 edges, then release -> an=F, seg=FF on edges 1-2; on edge 3 an=1110, seg=C0 (shadow=0). frame_tick stays 0 until the first capture at edge 32.
- Frame capture: drive bcd_word=12'h593 before edge 32 -> frame_tick=1 in the cycle after edge 32. Next frame: digit0 seg=B0, digit1 seg=90, digit2 seg=92. Digit3 seg=7F (hb=1); the following frame gives digit3 seg=FF.
- Tear-free: change bcd_word from 12'h593 to 12'h111 mid-frame (dsel==1) -> remaining digits still show 5/9/3. Value 1 (F9) appears only after the next frame_tick.
- Leading zeros: shadow=12'h005 with lz_blank=1 -> digit2 and digit1 slots have an low but seg=FF, digit0 seg=92. With lz_blank=0 -> digit2 and digit1 seg=C0.
- Disable and ghost blank: disp_en=0 for one full frame -> an=F, seg=FF throughout while div_cnt and dsel keep advancing. With disp_en=1, the first 2 cycles of every slot show an=F.
- Reset mid-operation: assert rst=0 while dsel==2 and div_cnt==5 -> next edge gives an=F, seg=FF, shadow=0, hb=0. After release, scanning restarts at digit0 showing C0.
